updown_cnt: RTL and testbench
=============================

# updown_cnt

Synchronous binary up/down counter with a direction input and a terminal-count flag. A general-purpose sequencing/timing primitive: the counter advances once per clock, incrementing or decrementing according to `down`. It sits directly under control logic that needs a reversible step count. By default it wraps modulo 2^WIDTH; saturation is a compile-time option.

## Interface
- `WIDTH`, default 4: counter width in bits, legal range ≥ 1.

Ports, in positional order, which is fixed:
- `ck` input 1: clock; all state changes occur on the rising edge.
- `res` input 1: reset, synchronous, active-high.
- `down` input 1: direction.
  - 0 counts up.
  - 1 counts down.
- `q` output WIDTH: current count, registered.
- `tc` output 1: terminal count, combinational from `q` and `down`.
  - Asserted when `down`=0 and `q`=2^WIDTH−1.
  - Asserted when `down`=1 and `q`=0.

## Operation
- The following priority is evaluated at every rising `ck`:
  1. `res`=1: `q` becomes 0. `down` is ignored, even if X/Z.
  2. `down`=0: `q` becomes `q`+1, modulo 2^WIDTH.
  3. `down`=1: `q` becomes `q`−1, modulo 2^WIDTH.
- The counter has no enable; it steps on every non-reset clock.
- Wrap-around in the default build:
  - Counting up from all-ones gives 0.
  - Counting down from 0 gives all-ones.
  - No extra flag is raised beyond `tc`.
- Direction change takes effect on the next edge. There is no pipeline and no lost or duplicated step: ...,9,A, then `down`=1, then 9,8,...
- `tc` follows `down` combinationally. Changing `down` can toggle `tc` without a clock edge.
- Arithmetic is unsigned WIDTH-bit; there are no carry or borrow outputs.

## Timing
- Latency: `q` reflects a step one clock after the edge that samples the inputs. The `q` update is a registered output with no combinational path from inputs.
- Reset:
  - Reset takes effect on the first rising edge with `res`=1.
  - `q`=0 after that edge, and `tc`=1 if `down`=1.
  - Before the first reset edge, `q` is undefined. No initial value is provided.
- Reset mid-count clears `q` to 0 at the next edge regardless of direction. Counting resumes from 0 on the first edge with `res`=0.
- Inputs must be stable around the rising edge of `ck` and meet setup/hold.

## Configuration
- Macro: `UPDOWN_CNT_SAT_EN`.
- Undefined (default): modulo wrap as above.
- Defined: saturating counter.
  - Counting up at all-ones holds all-ones.
  - Counting down at 0 holds 0.
  - `tc` keeps the same definition and stays high while saturated.
  - Reset behaviour is unchanged.

## Structure
- Shared package `updown_cnt_pkg`:
  - Localparam for the default width (4).
  - Direction encoding constants `DIR_UP`=1'b0 and `DIR_DOWN`=1'b1.
- The block is a single module: one clocked process for `q` and one continuous assignment for `tc`. No sub-module is natural.

## Test plan
All cases use WIDTH=4 unless noted.
- Reset: `res`=1 for one edge with `down`=X, then `res`=0 → `q`=0x0 after the reset edge.
- Up count: after reset, `down`=0 for 10 edges → `q` steps 1,2,…,0xA; `tc`=0 throughout.
- Reverse: from `q`=0xA, set `down`=1 for 10 edges → `q` steps 9,8,…,0. At `q`=0, `tc`=1.
- Wrap, default build:
  - From `q`=0 with `down`=1, one edge → `q`=0xF.
  - From `q`=0xF with `down`=0, one edge → `q`=0x0; `tc`=1 while `q`=0xF and counting up.
- Mid-count reset: at `q`=0x6 counting up, assert `res` for one edge → `q`=0x0; the next edge gives 0x1.
- Saturation, with `UPDOWN_CNT_SAT_EN` defined:
  - Hold `down`=0 for 20 edges → `q` stops at 0xF.
  - Then hold `down`=1 for 20 edges → `q` stops at 0x0.
  - `tc` stays 1 while saturated.

Source files
------------

// File: rtl/updown_cnt_pkg.sv
// -----------------------------------------------------------------------------
// updown_cnt_pkg
// Shared constants for the up/down counter: default width and the encoding
// of the direction input.
// Optional build macro for the counter: UPDOWN_CNT_SAT_EN (saturating mode).
// -----------------------------------------------------------------------------
package updown_cnt_pkg;

    // Width used when the instantiating code does not override WIDTH.
    localparam int DEFAULT_WIDTH = 4;

    // Direction encoding as seen on the `down` input.
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage : updown_cnt_pkg

// File: rtl/updown_cnt_if.sv
// -----------------------------------------------------------------------------
// updown_cnt_if
// Bundles the counter's data-side signals: direction in, count and terminal
// flag out.
// - master: the controlling logic. It drives the direction and observes the count.
// - slave:  the counter itself.
// -----------------------------------------------------------------------------
interface updown_cnt_if
    import updown_cnt_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             down;  // DIR_UP / DIR_DOWN
    logic [WIDTH-1:0] q;     // registered count
    logic             tc;    // terminal count for the current direction

    modport master (output down, input q, input tc);
    modport slave  (input down, output q, output tc);

endinterface : updown_cnt_if

// File: rtl/updown_cnt.sv
// -----------------------------------------------------------------------------
// updown_cnt
// Synchronous binary up/down counter with a terminal-count flag.
// - The count steps on every rising edge of `ck` that is not a reset edge.
// - `down` selects the direction and takes effect on the next edge.
// - `tc` is combinational from `q` and `down`. It flags the value at which the
//   next step in the current direction would wrap, or would hold when the
//   counter saturates.
//
// Build option:
// - UPDOWN_CNT_SAT_EN undefined (default): the counter wraps modulo 2^WIDTH.
// - UPDOWN_CNT_SAT_EN defined: the counter holds at all-ones when counting up
//   and at zero when counting down.
//
// Reset `res` is synchronous and active-high. Before the first reset edge,
// `q` is undefined.
// -----------------------------------------------------------------------------
module updown_cnt
    import updown_cnt_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             ck,
    input  logic             res,
    input  logic             down,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ZERO     = '0;
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    // Terminal count: all-ones when counting up, zero when counting down.
    assign tc = (down == DIR_DOWN) ? (q == ZERO) : (q == ALL_ONES);

    // Count register: reset has priority, then one step in the selected direction.
    // NOTE: sequential state uses non-blocking assignment so every flop samples
    // the pre-edge value of q; a blocking update here would race with readers.
    always_ff @(posedge ck) begin
        if (res) begin
            q <= ZERO;
`ifdef UPDOWN_CNT_SAT_EN
        end else if (tc) begin
            q <= q;
`endif
        end else if (down == DIR_UP) begin
            q <= q + ONE;
        end else begin
            q <= q - ONE;
        end
    end

endmodule : updown_cnt

// File: tb/tb_updown_cnt.sv
// -----------------------------------------------------------------------------
// tb_updown_cnt
// Directed, table-driven bench for updown_cnt at WIDTH=4.
// - Each vector either applies its inputs across one rising edge or applies
//   them with no edge, to check tc as a combinational output.
// - The expected count and tc come from the table.
// - The saturation sequence is built only when UPDOWN_CNT_SAT_EN is defined.
// -----------------------------------------------------------------------------
module tb_updown_cnt;
    import updown_cnt_pkg::*;

    localparam int W = 4;

    typedef struct {
        logic         edge_en;  // 1: step one clock edge; 0: combinational only
        logic         res;
        logic         down;
        logic [W-1:0] exp_q;
        logic         chk_tc;
        logic         exp_tc;
    } vec_t;

    logic ck;
    logic res;

    updown_cnt_if #(.WIDTH(W)) bus ();

    updown_cnt #(.WIDTH(W)) dut (
        .ck   (ck),
        .res  (res),
        .down (bus.down),
        .q    (bus.q),
        .tc   (bus.tc)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic void add(input logic e, input logic r, input logic d,
                                input logic [W-1:0] eq, input logic ct,
                                input logic et);
        vec_t v;
        v.edge_en = e;
        v.res     = r;
        v.down    = d;
        v.exp_q   = eq;
        v.chk_tc  = ct;
        v.exp_tc  = et;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic step(input logic r, input logic d);
        @(negedge ck);
        res      = r;
        bus.down = d;
        @(posedge ck);
        #1;
    endtask

    initial begin
        res      = 1'b0;
        bus.down = 1'b0;

        // Reset with the direction unknown, then observe tc in the reset state.
        add(1, 1, 1'bx, 4'h0, 0, 0);
        add(0, 1, 1,    4'h0, 1, 1);
        // Count up 1..A; tc stays low.
        for (int i = 1; i <= 10; i++) add(1, 0, 0, 4'(i), 1, 0);
        // Reverse from A down to 0; tc rises only at 0.
        for (int i = 9; i >= 0; i--) add(1, 0, 1, 4'(i), 1, (i == 0));
`ifndef UPDOWN_CNT_SAT_EN
        // Wrap down 0 -> F, flip direction without an edge, then wrap up F -> 0.
        add(1, 0, 1, 4'hF, 1, 0);
        add(0, 0, 0, 4'hF, 1, 1);
        add(1, 0, 0, 4'h0, 1, 0);
`else
        // Saturated at zero: another down step holds.
        add(1, 0, 1, 4'h0, 1, 1);
`endif
        // Mid-count reset while counting up at 6, then resume from 0.
        for (int i = 1; i <= 6; i++) add(1, 0, 0, 4'(i), 1, 0);
        add(1, 1, 0, 4'h0, 1, 0);
        add(1, 0, 0, 4'h1, 1, 0);
        add(1, 0, 0, 4'h2, 1, 0);
        // Reset while the direction is down clears q too, and tc then reads 1.
        add(1, 1, 1, 4'h0, 1, 1);
        add(1, 0, 0, 4'h1, 1, 0);

        foreach (vecs[i]) begin
            if (vecs[i].edge_en) begin
                step(vecs[i].res, vecs[i].down);
            end else begin
                res      = vecs[i].res;
                bus.down = vecs[i].down;
                #1;
            end
            check($sformatf("vec%0d q", i), 32'(bus.q), 32'(vecs[i].exp_q));
            if (vecs[i].chk_tc)
                check($sformatf("vec%0d tc", i), 32'(bus.tc), 32'(vecs[i].exp_tc));
        end

`ifdef UPDOWN_CNT_SAT_EN
        // Saturation: 20 up edges stop at F, then 20 down edges stop at 0.
        step(1'b1, 1'b0);
        check("sat reset q", 32'(bus.q), 32'h0);
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, DIR_UP);
            check($sformatf("sat up%0d q", i), 32'(bus.q), (i < 15) ? i : 15);
            check($sformatf("sat up%0d tc", i), 32'(bus.tc), (i >= 15) ? 1 : 0);
        end
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, DIR_DOWN);
            check($sformatf("sat dn%0d q", i), 32'(bus.q), (i < 15) ? 15 - i : 0);
            check($sformatf("sat dn%0d tc", i), 32'(bus.tc), (i >= 15) ? 1 : 0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_updown_cnt
